iris_axi_sram: RTL and testbench

IRIS_AXI_SRAM -- requirements
Module: iris_axi_sram

---
 rtl/iris_axi_pkg.sv | 34 +++
 rtl/iris_sram_1r1w.sv | 48 ++++
 rtl/iris_axi_sram.sv | 255 +++++++++++++++++++++++++
 tb/tb_iris_axi_sram.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iris_axi_pkg.sv
// Shared definitions for the IRIS AXI SRAM slave.
//   - AXI response codes and the INCR burst code
//   - Write and read FSM state encodings
//   - Byte-lane count of the storage array
//   - resp_code(): folds the decode-error and slave-error flags into an AXI
//     response. A decode error outranks a slave error.
package iris_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam int NUM_LANES = 3;

    typedef enum logic [1:0] {
        W_ADDR = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [1:0] resp_code(input logic dec, input logic slv);
        if (dec)      return RESP_DECERR;
        else if (slv) return RESP_SLVERR;
        else          return RESP_OKAY;
    endfunction

endpackage

// File: rtl/iris_sram_1r1w.sv
// Storage array: one write port with per-lane byte enables and one registered
// read port. The array has no reset.
//   clk          clock
//   we/waddr     write enable and word address
//   wbe          lane enables, one per 8-bit lane
//   wdata        write data
//   re/raddr     read enable and word address. rdata updates on the next edge
//                and holds its value while re is low.
//   rdata        registered read data
// A read and a write of the same word on the same edge return the old word.
module iris_sram_1r1w
    import iris_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [NUM_LANES-1:0]  wbe,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int LANE_W = DATA_WIDTH / NUM_LANES;

    logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // NOTE: the array and its read register have no reset. A reset port on an
    // array prevents mapping it to RAM macros.
    // NOTE: the non-blocking assignments make the read sample the word as it
    // was before this edge's write.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wbe[l]) begin
                    mem[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/iris_axi_sram.sv
// AXI4 slave in front of a word-addressed SRAM.
// Addresses are word addresses. Every burst is treated as INCR, with the
// address stepping by one word per beat and wrapping at 2**ADDR_WIDTH.
// Beats whose address is at or above 2**DEPTH_LOG2 return DECERR. Such a
// write beat is dropped, and such a read beat returns zero data.
// The write and read channels run independently.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   axi_aw*               write address channel (size/burst/lock/cache/prot/qos
//                         are accepted and ignored)
//   axi_w*                write data channel. wstrb[2:0] are the lane enables;
//                         wstrb[3] is ignored.
//   axi_b*                write response channel
//   axi_ar*               read address channel (the same fields are ignored)
//   axi_r*                read data channel
//
// Configuration macro IRIS_SRAM_BURST_EN:
//   - Defined: awlen and arlen (0..255) are honoured.
//   - Undefined: every transfer is a single beat, and a non-zero len gives a
//     SLVERR response unless the beat is a DECERR.
module iris_axi_sram
    import iris_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [ID_WIDTH-1:0]   axi_awid,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awlock,
    input  logic [3:0]            axi_awcache,
    input  logic [2:0]            axi_awprot,
    input  logic [3:0]            axi_awqos,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic [3:0]            axi_wstrb,
    input  logic                  axi_wlast,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic [1:0]            axi_bresp,
    output logic [ID_WIDTH-1:0]   axi_bid,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [ID_WIDTH-1:0]   axi_arid,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arlock,
    input  logic [3:0]            axi_arcache,
    input  logic [2:0]            axi_arprot,
    input  logic [3:0]            axi_arqos,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic [ID_WIDTH-1:0]   axi_rid
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> DEPTH_LOG2) == '0;
    endfunction

    // Burst lengths actually used, and whether the requested len is refused.
    logic [7:0] aw_len_eff, ar_len_eff;
    logic       aw_len_err, ar_len_err;

`ifdef IRIS_SRAM_BURST_EN
    assign aw_len_eff = axi_awlen;
    assign ar_len_eff = axi_arlen;
    assign aw_len_err = 1'b0;
    assign ar_len_err = 1'b0;
`else
    assign aw_len_eff = 8'd0;
    assign ar_len_eff = 8'd0;
    assign aw_len_err = (axi_awlen != 8'd0);
    assign ar_len_err = (axi_arlen != 8'd0);
`endif

    // Every burst is INCR, so the burst type and the sideband fields never
    // influence the logic.
    logic unused_ok;
    assign unused_ok = ^{axi_awsize, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                         axi_arsize, axi_arlock, axi_arcache, axi_arprot, axi_arqos,
                         axi_wstrb[3], axi_awburst != BURST_INCR, axi_arburst != BURST_INCR};

    // ---------------------------------------------------------------- write
    w_state_t              w_state, w_state_nx;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic                  w_dec, w_slv;
    logic                  aw_fire, w_fire, w_last_beat, w_in_range, w_last_bad;

    assign aw_fire     = axi_awvalid && axi_awready;
    assign w_fire      = axi_wvalid && axi_wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_in_range  = in_range(w_addr);
    assign w_last_bad  = (axi_wlast != w_last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_ADDR;
        else        w_state <= w_state_nx;
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case infers a latch.
    always_comb begin
        w_state_nx  = w_state;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        case (w_state)
            W_ADDR: begin
                axi_awready = 1'b1;
                if (axi_awvalid) w_state_nx = W_DATA;
            end
            W_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid && w_last_beat) w_state_nx = W_RESP;
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) w_state_nx = W_ADDR;
            end
            default: w_state_nx = W_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_dec     <= 1'b0;
            w_slv     <= 1'b0;
            axi_bid   <= '0;
            axi_bresp <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                w_addr  <= axi_awaddr;
                w_len   <= aw_len_eff;
                w_cnt   <= '0;
                w_dec   <= 1'b0;
                w_slv   <= aw_len_err;
                axi_bid <= axi_awid;
            end
            if (w_fire) begin
                w_addr <= w_addr + ADDR_ONE;
                w_cnt  <= w_cnt + 8'd1;
                if (!w_in_range) w_dec <= 1'b1;
                if (w_last_bad)  w_slv <= 1'b1;
                // The error flags of the current beat are folded in directly,
                // because the registered flags only update at this same edge.
                if (w_last_beat) axi_bresp <= resp_code(w_dec || !w_in_range, w_slv || w_last_bad);
            end
        end
    end

    // ----------------------------------------------------------------- read
    r_state_t              r_state, r_state_nx;
    logic [ADDR_WIDTH-1:0] r_addr, r_fetch_addr;
    logic [7:0]            r_len, r_cnt;
    logic                  r_dec, r_slv;
    logic                  ar_fire, r_fire, r_last, r_fetch;
    logic [DATA_WIDTH-1:0] ram_q;

    assign ar_fire = axi_arvalid && axi_arready;
    assign r_fire  = axi_rvalid && axi_rready;
    assign r_last  = (r_cnt == r_len);

    // The next word is fetched on the accepting edge, so rdata for the
    // following beat is ready one cycle later with no bubble. Without a fetch
    // the read register holds its value, which keeps rdata stable during
    // stalls.
    assign r_fetch      = ar_fire || (r_fire && !r_last);
    assign r_fetch_addr = ar_fire ? axi_araddr : r_addr + ADDR_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_ADDR;
        else        r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx  = r_state;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        case (r_state)
            R_ADDR: begin
                axi_arready = 1'b1;
                if (axi_arvalid) r_state_nx = R_DATA;
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                if (axi_rready && r_last) r_state_nx = R_ADDR;
            end
            default: r_state_nx = R_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_dec     <= 1'b0;
            r_slv     <= 1'b0;
            axi_rid   <= '0;
            axi_rresp <= RESP_OKAY;
        end else if (ar_fire) begin
            r_addr    <= axi_araddr;
            r_len     <= ar_len_eff;
            r_cnt     <= '0;
            r_slv     <= ar_len_err;
            axi_rid   <= axi_arid;
            r_dec     <= !in_range(r_fetch_addr);
            axi_rresp <= resp_code(!in_range(r_fetch_addr), ar_len_err);
        end else if (r_fetch) begin
            r_addr    <= r_fetch_addr;
            r_cnt     <= r_cnt + 8'd1;
            r_dec     <= !in_range(r_fetch_addr);
            axi_rresp <= resp_code(!in_range(r_fetch_addr), r_slv);
        end
    end

    assign axi_rdata = (axi_rvalid && !r_dec) ? ram_q : '0;
    assign axi_rlast = axi_rvalid && r_last;

    iris_sram_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk   (clk),
        .we    (w_fire && w_in_range),
        .waddr (w_addr[DEPTH_LOG2-1:0]),
        .wbe   (axi_wstrb[NUM_LANES-1:0]),
        .wdata (axi_wdata),
        .re    (r_fetch),
        .raddr (r_fetch_addr[DEPTH_LOG2-1:0]),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_iris_axi_sram.sv
// Self-checking bench for iris_axi_sram.
// A reference model keeps a sparse word memory and computes the expected
// response, data, rlast and rid of every beat. The model works from the
// address arithmetic and the error rules only.
// Build with IRIS_SRAM_BURST_EN defined to exercise multi-beat bursts. The
// same stimulus also runs in the single-beat build, where the model predicts
// that behaviour instead.
module tb_iris_axi_sram;

`ifdef IRIS_SRAM_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam int DEPTH  = 1024;
    localparam int BUDGET = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        axi_awvalid = 0, axi_awready;
    logic [15:0] axi_awaddr = 0;
    logic [3:0]  axi_awid = 0;
    logic [7:0]  axi_awlen = 0;
    logic [2:0]  axi_awsize = 0;
    logic [1:0]  axi_awburst = 0;
    logic        axi_awlock = 0;
    logic [3:0]  axi_awcache = 0;
    logic [2:0]  axi_awprot = 0;
    logic [3:0]  axi_awqos = 0;
    logic        axi_wvalid = 0, axi_wready;
    logic [23:0] axi_wdata = 0;
    logic [3:0]  axi_wstrb = 0;
    logic        axi_wlast = 0;
    logic        axi_bvalid, axi_bready = 0;
    logic [1:0]  axi_bresp;
    logic [3:0]  axi_bid;
    logic        axi_arvalid = 0, axi_arready;
    logic [15:0] axi_araddr = 0;
    logic [3:0]  axi_arid = 0;
    logic [7:0]  axi_arlen = 0;
    logic [2:0]  axi_arsize = 0;
    logic [1:0]  axi_arburst = 0;
    logic        axi_arlock = 0;
    logic [3:0]  axi_arcache = 0;
    logic [2:0]  axi_arprot = 0;
    logic [3:0]  axi_arqos = 0;
    logic        axi_rvalid, axi_rready = 0;
    logic [23:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic [3:0]  axi_rid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] ref_mem [int];

    always #5 clk = ~clk;

    iris_axi_sram dut (
        .clk(clk), .rst_n(rst_n),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
        .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic void ref_write(input logic [15:0] a, input logic [23:0] d, input logic [2:0] be);
        logic [23:0] cur;
        cur = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 24'hxxxxxx;
        for (int l = 0; l < 3; l++) begin
            if (be[l]) cur[8*l +: 8] = d[8*l +: 8];
        end
        ref_mem[int'(a)] = cur;
    endfunction

    function automatic logic [23:0] known_bits(input logic [23:0] v);
        logic [23:0] m;
        for (int b = 0; b < 24; b++) m[b] = (v[b] === 1'b0) || (v[b] === 1'b1);
        return m;
    endfunction

    function automatic logic [1:0] exp_resp(input bit dec, input bit slv);
        return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    // ------------------------------------------------------ bus helpers
    function automatic logic chan_ready(input int ch);
        case (ch)
            0: return axi_awready;
            1: return axi_wready;
            2: return axi_bvalid;
            3: return axi_arready;
            default: return 1'b0;
        endcase
    endfunction

    // Returns at the negedge where the channel is ready, so the handshake
    // completes on the following posedge.
    task automatic wait_hs(input int ch, input string tag);
        int n = 0;
        @(negedge clk);
        while (!chan_ready(ch) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n >= BUDGET), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ignored();
        axi_awsize = 3'($urandom); axi_awburst = 2'($urandom); axi_awlock = 1'($urandom);
        axi_awcache = 4'($urandom); axi_awprot = 3'($urandom); axi_awqos = 4'($urandom);
        axi_arsize = 3'($urandom); axi_arburst = 2'($urandom); axi_arlock = 1'($urandom);
        axi_arcache = 4'($urandom); axi_arprot = 3'($urandom); axi_arqos = 4'($urandom);
    endtask

    // wlast_beat < 0 places wlast on the natural last beat.
    task automatic do_write(input logic [15:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [3:0] strb, input logic [23:0] data0,
                            input int wlast_beat, input string tag);
        int          eff;
        bit          dec, slv;
        logic [15:0] a;
        logic [23:0] d;
        eff = BURST_EN ? int'(len) : 0;
        slv = !BURST_EN && (len != 8'd0);
        dec = 1'b0;
        if (wlast_beat < 0) wlast_beat = eff;
        drive_ignored();
        axi_awvalid = 1'b1; axi_awaddr = addr; axi_awid = id; axi_awlen = len;
        wait_hs(0, {tag, "_aw"});
        step();
        axi_awvalid = 1'b0;
        for (int i = 0; i <= eff; i++) begin
            repeat ($urandom_range(0, 1)) step();
            a = addr + 16'(i);
            d = data0 + 24'(i);
            axi_wvalid = 1'b1; axi_wdata = d; axi_wstrb = strb; axi_wlast = (i == wlast_beat);
            wait_hs(1, {tag, "_w"});
            step();
            axi_wvalid = 1'b0; axi_wlast = 1'b0;
            if (int'(a) < DEPTH) ref_write(a, d, strb[2:0]);
            else                 dec = 1'b1;
            if ((i == wlast_beat) != (i == eff)) slv = 1'b1;
        end
        repeat ($urandom_range(0, 2)) step();
        axi_bready = 1'b1;
        wait_hs(2, {tag, "_b"});
        check({tag, "_bresp"}, 32'(axi_bresp), 32'(exp_resp(dec, slv)));
        check({tag, "_bid"}, 32'(axi_bid), 32'(id));
        step();
        axi_bready = 1'b0;
        check({tag, "_aw_after_b"}, 32'(axi_awready), 32'd1);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input bit stall, input string tag);
        int          eff, i, guard;
        bit          slv, dec;
        logic [15:0] a;
        logic [23:0] exp_d, mask;
        eff = BURST_EN ? int'(len) : 0;
        slv = !BURST_EN && (len != 8'd0);
        drive_ignored();
        axi_arvalid = 1'b1; axi_araddr = addr; axi_arid = id; axi_arlen = len;
        wait_hs(3, {tag, "_ar"});
        step();
        axi_arvalid = 1'b0;
        check({tag, "_rvalid_first"}, 32'(axi_rvalid), 32'd1);
        i = 0;
        guard = 0;
        while (i <= eff && guard < 4 * BUDGET) begin
            axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            a   = addr + 16'(i);
            dec = int'(a) >= DEPTH;
            if (dec)                          exp_d = 24'h0;
            else if (ref_mem.exists(int'(a))) exp_d = ref_mem[int'(a)];
            else                              exp_d = 24'hxxxxxx;
            mask = known_bits(exp_d);
            check({tag, "_rvalid"}, 32'(axi_rvalid), 32'd1);
            check({tag, "_rresp"}, 32'(axi_rresp), 32'(exp_resp(dec, slv)));
            check({tag, "_rlast"}, 32'(axi_rlast), 32'(i == eff));
            check({tag, "_rid"}, 32'(axi_rid), 32'(id));
            if (mask != 24'h0) check({tag, "_rdata"}, 32'(axi_rdata & mask), 32'(exp_d & mask));
            step();
            if (axi_rready) i++;
            guard++;
        end
        axi_rready = 1'b0;
        check({tag, "_burst_done"}, 32'(i), 32'(eff + 1));
        check({tag, "_rvalid_end"}, 32'(axi_rvalid), 32'd0);
        check({tag, "_arready_end"}, 32'(axi_arready), 32'd1);
    endtask

    // ------------------------------------------------------ stimulus
    initial begin
        logic [15:0] addr;
        int          sel;

        // Values driven while reset is held.
        #3;
        check("rst_awready", 32'(axi_awready), 32'd1);
        check("rst_arready", 32'(axi_arready), 32'd1);
        check("rst_wready",  32'(axi_wready),  32'd0);
        check("rst_bvalid",  32'(axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(axi_rvalid),  32'd0);
        check("rst_bresp",   32'(axi_bresp),   32'd0);
        check("rst_rresp",   32'(axi_rresp),   32'd0);
        check("rst_rdata",   32'(axi_rdata),   32'd0);
        check("rst_rlast",   32'(axi_rlast),   32'd0);
        check("rst_bid",     32'(axi_bid),     32'd0);
        check("rst_rid",     32'(axi_rid),     32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Basic write and readback, followed by a single-lane overwrite.
        do_write(16'h0005, 4'h3, 8'd0, 4'b0111, 24'h123456, -1, "basic_wr");
        do_read (16'h0005, 4'h3, 8'd0, 1'b0, "basic_rd");
        do_write(16'h0005, 4'h4, 8'd0, 4'b0001, 24'hAABBCC, -1, "strb_wr");
        do_read (16'h0005, 4'h4, 8'd0, 1'b0, "strb_rd");
        check("strb_model", 32'(ref_mem[5]), 32'h1234CC);

        // Four-beat burst read back under a toggling rready. The single-beat
        // build answers with a single SLVERR beat.
        do_write(16'h0010, 4'h7, 8'd3, 4'b1111, 24'h0A0B00, -1, "burst_wr");
        do_read (16'h0010, 4'h8, 8'd3, 1'b1, "burst_rd");

        // Decode errors. The write to 0x0400 must not alias onto word 0.
        do_write(16'h0000, 4'h1, 8'd0, 4'b0111, 24'h0BEEF0, -1, "dec_pre");
        do_read (16'h0400, 4'h2, 8'd0, 1'b0, "dec_rd");
        do_write(16'h0400, 4'h2, 8'd0, 4'b0111, 24'h777777, -1, "dec_wr");
        do_read (16'h0000, 4'h2, 8'd0, 1'b0, "dec_alias");

        // Early wlast on beat 1 of a three-beat burst.
        do_write(16'h0020, 4'h9, 8'd2, 4'b0111, 24'h202020, 1, "early_wlast");

        // Address wrap from 0xFFFE through 0x0000.
        do_write(16'hFFFE, 4'h5, 8'd3, 4'b0111, 24'h55AA00, -1, "wrap_wr");
        do_read (16'hFFFF, 4'h5, 8'd2, 1'b0, "wrap_rd");

        // A write and a read of one word on the same edge.
        do_write(16'h0007, 4'h1, 8'd0, 4'b0111, 24'h000001, -1, "rbw_pre");
        axi_awvalid = 1'b1; axi_awaddr = 16'h0007; axi_awid = 4'h5; axi_awlen = 8'd0;
        wait_hs(0, "rbw_aw");
        step();
        axi_awvalid = 1'b0;
        axi_wvalid = 1'b1; axi_wdata = 24'h000002; axi_wstrb = 4'b0111; axi_wlast = 1'b1;
        axi_arvalid = 1'b1; axi_araddr = 16'h0007; axi_arid = 4'h6; axi_arlen = 8'd0;
        @(negedge clk);
        check("rbw_wready", 32'(axi_wready), 32'd1);
        check("rbw_arready", 32'(axi_arready), 32'd1);
        step();
        axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_arvalid = 1'b0;
        ref_write(16'h0007, 24'h000002, 3'b111);
        @(negedge clk);
        check("rbw_rvalid", 32'(axi_rvalid), 32'd1);
        check("rbw_old", 32'(axi_rdata), 32'h000001);
        axi_rready = 1'b1;
        step();
        axi_rready = 1'b0;
        axi_bready = 1'b1;
        wait_hs(2, "rbw_b");
        check("rbw_bresp", 32'(axi_bresp), 32'd0);
        step();
        axi_bready = 1'b0;
        do_read(16'h0007, 4'h6, 8'd0, 1'b0, "rbw_new");

        // Random traffic: in-range words, the decode boundary and the wrap.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      addr = 16'($urandom_range(0, 47));
            else if (sel < 8) addr = 16'(1020 + $urandom_range(0, 7));
            else              addr = 16'(16'hFFFC + $urandom_range(0, 3));
            do_write(addr, 4'($urandom), 8'($urandom_range(0, 5)), 4'($urandom),
                     24'($urandom), -1, "rnd_wr");
            if ($urandom_range(0, 1) == 1) begin
                do_read(addr, 4'($urandom), 8'($urandom_range(0, 5)), 1'($urandom), "rnd_rd");
            end
        end

        // Reset in the middle of a read burst aborts it silently.
        axi_arvalid = 1'b1; axi_araddr = 16'h0010; axi_arid = 4'h3; axi_arlen = 8'd3;
        wait_hs(3, "abort_ar");
        step();
        axi_arvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_rd_rvalid", 32'(axi_rvalid), 32'd0);
        check("abort_rd_arready", 32'(axi_arready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset after the write address handshake leaves no B response.
        axi_awvalid = 1'b1; axi_awaddr = 16'h0030; axi_awid = 4'h2; axi_awlen = 8'd2;
        wait_hs(0, "abort_aw");
        step();
        axi_awvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr_wready", 32'(axi_wready), 32'd0);
        check("abort_wr_awready", 32'(axi_awready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        axi_bready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_bvalid", 32'(axi_bvalid), 32'd0);
            check("abort_rvalid", 32'(axi_rvalid), 32'd0);
        end
        axi_bready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
